bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_DEV, default 4: number of requesting devices; fixed at 4 for this release.
REQ-002 Parameter GRANT_TIMEOUT, default 8: cycles a grant waits for hold before being withdrawn.
REQ-003 clk  input  1  system clock; one clock domain; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 request  input  4  per-device bus request, bit i from device i's arbiter interface handler.
REQ-006 request_type  input  4  per-device type: 0 normal read/write, 1 priority write-back (PWB).
REQ-007 hold  input  4  per-device hold; high = owner still transferring, do not regrant.
REQ-008 grant  output  4  one-hot-or-zero grant, bit i to device i.
REQ-009 active  output  1  broadcast bus-active, high while a transfer is in progress.
REQ-010 owner  output  2  index of current grantee; bus mux select; valid while grant nonzero.

Function
REQ-011 States: IDLE, GRANT_WAIT, BUSY; all outputs registered.
REQ-012 IDLE: grant=0, active=0; if any request bit high, select winner, set grant[winner]=1, owner=winner, load timeout counter with GRANT_TIMEOUT-1, go GRANT_WAIT on the same edge.
REQ-013 Selection: any request with request_type=1 beats all normal requests; within the selected class, round-robin starting at rr_ptr, scanning upward with wrap 3->0.
REQ-014 GRANT_WAIT: hold grant; if hold[owner]=1 go BUSY and set active=1.
REQ-015 GRANT_WAIT: if request[owner]=0 and hold[owner]=0, drop grant and go IDLE; rr_ptr unchanged.
REQ-016 GRANT_WAIT: if counter reaches 0 with hold[owner]=0, drop grant, go IDLE, rr_ptr=owner+1 (mod 4) so a dead requester cannot starve others.
REQ-017 BUSY: grant and active held while hold[owner]=1; no re-arbitration, new PWB requests do not preempt.
REQ-018 BUSY: on hold[owner]=0, next edge grant=0, active=0, rr_ptr=owner+1 (mod 4), go IDLE; minimum one IDLE cycle between grants.
REQ-019 hold bits of non-owners are ignored in every state.
REQ-020 Request-to-grant latency from IDLE: one cycle; grant remains until hold release or timeout.
REQ-021 owner retains last value when grant=0.
REQ-022 Timeout counter width: 3 bits for GRANT_TIMEOUT=8; decrement saturates at 0.

Reset
REQ-023 On rst=1 at an edge: state=IDLE, grant=0, active=0, owner=0, rr_ptr=0, counter=0, regardless of current state, including mid-BUSY.
REQ-024 First arbitration occurs on the first edge with rst=0 and a request present.

Structure
REQ-025 State encodings, N_DEV and GRANT_TIMEOUT default shall be defined in the shared define.v constants file.
REQ-026 Winner selection shall be a combinational sub-module rr_picker (inputs req[3:0], ptr[1:0]; outputs valid, idx[1:0]), instantiated twice (PWB class, normal class).
REQ-027 Total RTL 120-400 lines including rr_picker.

Verification
REQ-028 Reset, then request=0001, type=0; device 0 raises hold 2 cycles after grant and keeps it 4 cycles -> grant=0001 one cycle after request, active high exactly while hold high, grant=0 one cycle after hold drop, rr_ptr=1.
REQ-029 request=1111 all normal, each holds 1 cycle, requests stay high -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-030 request=0011, type=0010, rr_ptr=0 -> device 1 granted first (PWB wins); device 0 next.
REQ-031 Device 2 requests, never raises hold -> grant=0100 for 8 cycles then 0, rr_ptr=3.
REQ-032 In BUSY with owner=1, device 3 raises PWB request and spurious hold[3] -> no change to grant=0010 until hold[1] drops; then device 3 granted.
REQ-033 rst asserted mid-BUSY -> next edge grant=0, active=0, owner=0, state IDLE; hold still high has no effect until a new grant.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared constants and state encoding for the bus arbiter.
// Imported by bus_arbiter and rr_picker.
package bus_arbiter_pkg;

  localparam int N_DEV_DEF   = 4;
  localparam int GRANT_TO_DEF = 8;
  localparam int IDX_W       = 2;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_GRANT_WAIT = 2'd1,
    S_BUSY       = 2'd2
  } state_e;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or above ptr, wrapping 3->0.
// Ports: req[3:0], ptr[1:0] in; valid, idx[1:0] out. Combinational.
module rr_picker
  import bus_arbiter_pkg::*;
(
  input  logic [3:0]       req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the slot closest to ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + IDX_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Bus arbiter: PWB-first round-robin grant with hold and grant timeout.
// Ports: clk, rst (sync, high), request/request_type/hold in; grant/active/owner out.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_DEV         = N_DEV_DEF,
  parameter int GRANT_TIMEOUT = GRANT_TO_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] request,
  input  logic [N_DEV-1:0] request_type,
  input  logic [N_DEV-1:0] hold,
  output logic [N_DEV-1:0] grant,
  output logic             active,
  output logic [IDX_W-1:0] owner
);

  localparam int CNT_W = $clog2(GRANT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GRANT_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [N_DEV-1:0] grant_q, grant_d;
  logic             active_q, active_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       pwb_req, nrm_req;
  logic             pwb_vld, nrm_vld, win_vld;
  logic [IDX_W-1:0] pwb_idx, nrm_idx, win_idx;

  assign pwb_req = request & request_type;
  assign nrm_req = request & ~request_type;

  rr_picker u_pick_pwb (
    .req   (pwb_req),
    .ptr   (rr_q),
    .valid (pwb_vld),
    .idx   (pwb_idx)
  );

  rr_picker u_pick_nrm (
    .req   (nrm_req),
    .ptr   (rr_q),
    .valid (nrm_vld),
    .idx   (nrm_idx)
  );

  assign win_vld = pwb_vld | nrm_vld;
  assign win_idx = pwb_vld ? pwb_idx : nrm_idx;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    active_d = active_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        grant_d  = '0;
        active_d = 1'b0;
        if (win_vld) begin
          grant_d[win_idx] = 1'b1;
          owner_d = win_idx;
          cnt_d   = CNT_LOAD;
          state_d = S_GRANT_WAIT;
        end
      end
      S_GRANT_WAIT: begin
        if (hold[owner_q]) begin
          active_d = 1'b1;
          state_d  = S_BUSY;
        end else if (!request[owner_q]) begin
          // Requester gave up: no penalty, pointer stays.
          grant_d = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          // Dead requester: move pointer past it.
          grant_d = '0;
          rr_d    = owner_q + IDX_W'(1);
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_BUSY: begin
        if (!hold[owner_q]) begin
          grant_d  = '0;
          active_d = 1'b0;
          rr_d     = owner_q + IDX_W'(1);
          state_d  = S_IDLE;
        end
      end
      default: begin
        grant_d  = '0;
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      active_q <= 1'b0;
      owner_q  <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign grant  = grant_q;
  assign active = active_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table, directed
// sequences, then random traffic against a behavioural model.
module tb_bus_arbiter;

  localparam int TMO = 8;

  logic       clk;
  logic       rst;
  logic [3:0] request;
  logic [3:0] request_type;
  logic [3:0] hold;
  logic [3:0] grant;
  logic       active;
  logic [1:0] owner;

  int n_checks;
  int n_fail;

  bus_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .request      (request),
    .request_type (request_type),
    .hold         (hold),
    .grant        (grant),
    .active       (active),
    .owner        (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] rq;
    logic [3:0] tp;
    logic [3:0] hd;
    logic [3:0] g;
    logic       a;
    logic [1:0] o;
  } vec_t;

  vec_t tbl[$];

  task automatic step(input logic r, input logic [3:0] rq,
                      input logic [3:0] tp, input logic [3:0] hd);
    rst          = r;
    request      = rq;
    request_type = tp;
    hold         = hd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] g,
                     input logic a, input logic [1:0] o);
    n_checks++;
    if (grant !== g || active !== a || owner !== o) begin
      n_fail++;
      $display("FAIL %s: got grant=%b active=%b owner=%0d, expected grant=%b active=%b owner=%0d",
               nm, grant, active, owner, g, a, o);
    end
  endtask

  function automatic logic [3:0] oh(input int d);
    logic [3:0] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  // Behavioural model state
  bit m_granted, m_xfer;
  int m_owner, m_ptr, m_age;

  task automatic model(input logic r, input logic [3:0] rq,
                       input logic [3:0] tp, input logic [3:0] hd);
    bit done;
    if (r) begin
      m_granted = 0; m_xfer = 0; m_owner = 0; m_ptr = 0; m_age = 0;
    end else if (!m_granted) begin
      done = 0;
      for (int cls = 1; cls >= 0; cls--)
        for (int k = 0; k < 4; k++) begin
          int d;
          d = (m_ptr + k) % 4;
          if (!done && rq[d] && tp[d] == cls[0]) begin
            done = 1; m_granted = 1; m_owner = d; m_age = 0;
          end
        end
    end else if (m_xfer) begin
      if (!hd[m_owner]) begin
        m_granted = 0; m_xfer = 0; m_ptr = (m_owner + 1) % 4;
      end
    end else if (hd[m_owner]) begin
      m_xfer = 1;
    end else if (!rq[m_owner]) begin
      m_granted = 0;
    end else if (m_age == TMO - 1) begin
      m_granted = 0; m_ptr = (m_owner + 1) % 4;
    end else begin
      m_age++;
    end
  endtask

  initial begin
    logic [3:0] rq, tp, hd;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; request = '0; request_type = '0; hold = '0;

    // reset; single normal transfer with hold for 4 cycles
    tbl.push_back('{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0});
    tbl.push_back('{1'b0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 2'd0});
    tbl.push_back('{1'b0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 2'd0});
    tbl.push_back('{1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1, 2'd0});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0});
    // PWB beats normal at ptr 0
    tbl.push_back('{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0});
    tbl.push_back('{1'b0, 4'h3, 4'h2, 4'h0, 4'h2, 1'b0, 2'd1});
    tbl.push_back('{1'b0, 4'h3, 4'h2, 4'h2, 4'h2, 1'b1, 2'd1});
    tbl.push_back('{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 2'd1});
    tbl.push_back('{1'b0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0, 2'd0});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0});
    // BUSY owner 1 not preempted by PWB + spurious hold on 3
    tbl.push_back('{1'b0, 4'h2, 4'h0, 4'h0, 4'h2, 1'b0, 2'd1});
    tbl.push_back('{1'b0, 4'h2, 4'h0, 4'h2, 4'h2, 1'b1, 2'd1});
    tbl.push_back('{1'b0, 4'hA, 4'h8, 4'hA, 4'h2, 1'b1, 2'd1});
    tbl.push_back('{1'b0, 4'hA, 4'h8, 4'hA, 4'h2, 1'b1, 2'd1});
    tbl.push_back('{1'b0, 4'hA, 4'h8, 4'h8, 4'h0, 1'b0, 2'd1});
    tbl.push_back('{1'b0, 4'hA, 4'h8, 4'h8, 4'h8, 1'b0, 2'd3});
    tbl.push_back('{1'b0, 4'h8, 4'h8, 4'h8, 4'h8, 1'b1, 2'd3});
    tbl.push_back('{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].rq, tbl[i].tp, tbl[i].hd);
      chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].a, tbl[i].o);
    end

    // all-normal round robin 0,1,2,3,0 with an idle gap each time
    step(1'b1, 4'h0, 4'h0, 4'h0);
    begin
      int ord[5];
      ord = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
        step(1'b0, 4'hF, 4'h0, 4'h0);
        chk($sformatf("rr_grant%0d", i), oh(ord[i]), 1'b0, 2'(ord[i]));
        step(1'b0, 4'hF, 4'h0, oh(ord[i]));
        chk($sformatf("rr_busy%0d", i), oh(ord[i]), 1'b1, 2'(ord[i]));
        step(1'b0, 4'hF, 4'h0, 4'h0);
        chk($sformatf("rr_idle%0d", i), 4'h0, 1'b0, 2'(ord[i]));
      end
    end

    // dead requester 2: 8 granted cycles, then pointer lands on 3
    step(1'b1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < TMO; i++) begin
      step(1'b0, 4'h4, 4'h0, 4'h0);
      chk($sformatf("tmo_hold%0d", i), 4'h4, 1'b0, 2'd2);
    end
    step(1'b0, 4'h4, 4'h0, 4'h0);
    chk("tmo_drop", 4'h0, 1'b0, 2'd2);
    step(1'b0, 4'hF, 4'h0, 4'h0);
    chk("tmo_ptr3", 4'h8, 1'b0, 2'd3);

    // reset in the middle of a transfer
    step(1'b1, 4'h0, 4'h0, 4'h0);
    step(1'b0, 4'h2, 4'h0, 4'h0);
    step(1'b0, 4'h2, 4'h0, 4'h2);
    chk("mid_busy", 4'h2, 1'b1, 2'd1);
    step(1'b1, 4'h2, 4'h0, 4'h2);
    chk("mid_rst", 4'h0, 1'b0, 2'd0);
    step(1'b0, 4'h0, 4'h0, 4'h2);
    chk("post_rst0", 4'h0, 1'b0, 2'd0);
    step(1'b0, 4'h0, 4'h0, 4'h2);
    chk("post_rst1", 4'h0, 1'b0, 2'd0);
    step(1'b0, 4'h4, 4'h0, 4'h2);
    chk("regrant", 4'h4, 1'b0, 2'd2);
    step(1'b0, 4'h4, 4'h0, 4'h2);
    chk("nonowner_hold", 4'h4, 1'b0, 2'd2);

    // random traffic against the model
    rq = '0; hd = '0;
    step(1'b1, 4'h0, 4'h0, 4'h0);
    model(1'b1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 4000; i++) begin
      logic r;
      r  = ($urandom_range(0, 199) == 0);
      rq = rq ^ 4'($urandom & $urandom & $urandom);
      tp = 4'($urandom);
      hd = 4'($urandom & $urandom);
      step(r, rq, tp, hd);
      model(r, rq, tp, hd);
      chk($sformatf("rnd%0d", i),
          m_granted ? oh(m_owner) : 4'h0, m_xfer, 2'(m_owner));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
